// File: rtl/call_stack_pred_pkg.sv
// Shared constants and types for the return-address call stack predictor.
// The width and depth defaults are the same constants the jump decoder uses.
package call_stack_pred_pkg;

  // Return-address width shared with the jump decoder.
  localparam int CS_IP_WIDTH = 48;

  // Number of return-address entries (power of two).
  localparam int CS_DEPTH = 16;

  // Stack operation selected for the current cycle.
  typedef enum logic [2:0] {
    CS_OP_HOLD    = 3'd0,
    CS_OP_PUSH    = 3'd1,
    CS_OP_POP     = 3'd2,
    CS_OP_SWAP    = 3'd3,
    CS_OP_RESTORE = 3'd4
  } cs_op_e;

  // Priority: restore beats push/pop and ignores in_en; an empty-stack pop holds.
  // Reset priority is applied by the caller, which gates the decoded operation.
  function automatic cs_op_e cs_decode_op(
    input logic restore,
    input logic in_en,
    input logic push,
    input logic pop,
    input logic non_empty
  );
    cs_op_e op;
    op = CS_OP_HOLD;
    if (restore) begin
      op = CS_OP_RESTORE;
    end else if (in_en) begin
      if (push && pop) begin
        op = CS_OP_SWAP;
      end else if (push) begin
        op = CS_OP_PUSH;
      end else if (pop && non_empty) begin
        op = CS_OP_POP;
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/call_stack_pred_cs_ram.sv
// Return-address storage: one synchronous write port and one asynchronous
// read port. Contents are never cleared.
module cs_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Single write port; entries are left untouched by reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Zero-latency read of the addressed entry.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack_pred.sv
// Circular return-address stack with branch checkpoint/restore support.
// The top entry is read combinationally; pointer and occupancy are registered
// and exported so each branch can carry a checkpoint for mispredict recovery.
import call_stack_pred_pkg::*;

module call_stack_pred #(
  parameter int DEPTH    = CS_DEPTH,
  parameter int IP_WIDTH = CS_IP_WIDTH,
  parameter int PW       = $clog2(DEPTH),
  parameter int CW       = PW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_en,
  input  logic                pushCallStack,
  input  logic                popCallStack,
  input  logic [IP_WIDTH-1:0] push_addr,
  output logic [IP_WIDTH-1:0] top_addr,
  output logic                top_vld,
  output logic [PW-1:0]       ckpt_ptr,
  output logic [CW-1:0]       ckpt_cnt,
  input  logic                restore,
  input  logic [PW-1:0]       restore_ptr,
  input  logic [CW-1:0]       restore_cnt,
  input  logic [IP_WIDTH-1:0] restore_top
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]       r_tos;
  logic [CW-1:0]       r_cnt;

  cs_op_e              w_op;
  logic [PW-1:0]       w_tos_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_we;
  logic [PW-1:0]       w_waddr;
  logic [IP_WIDTH-1:0] w_wdata;
  logic [IP_WIDTH-1:0] w_rdata;

  // Decode this cycle's stack operation.
  assign w_op = cs_decode_op(restore, in_en, pushCallStack, popCallStack,
                             (r_cnt != '0));

  // Next pointer/occupancy and the single write request for the entry array.
  // Pointer arithmetic wraps modulo DEPTH because DEPTH is a power of two.
  always_comb begin
    w_tos_nxt = r_tos;
    w_cnt_nxt = r_cnt;
    w_we      = 1'b0;
    w_waddr   = r_tos;
    w_wdata   = push_addr;
    case (w_op)
      CS_OP_PUSH: begin
        // A full stack overwrites its oldest entry; occupancy saturates.
        w_tos_nxt = r_tos + PW'(1);
        w_cnt_nxt = (r_cnt == FULL_CNT) ? r_cnt : (r_cnt + CW'(1));
        w_we      = 1'b1;
        w_waddr   = r_tos + PW'(1);
      end
      CS_OP_POP: begin
        // Entry contents stay; only the pointer moves back.
        w_tos_nxt = r_tos - PW'(1);
        w_cnt_nxt = r_cnt - CW'(1);
      end
      CS_OP_SWAP: begin
        // Return-then-call replaces the top in place; an empty stack gains one.
        w_we      = 1'b1;
        w_waddr   = r_tos;
        w_cnt_nxt = (r_cnt == '0) ? CW'(1) : r_cnt;
      end
      CS_OP_RESTORE: begin
        // The checkpointed top is rewritten because younger pushes may have
        // overwritten that slot since the checkpoint was taken.
        w_tos_nxt = restore_ptr;
        w_cnt_nxt = restore_cnt;
        w_we      = 1'b1;
        w_waddr   = restore_ptr;
        w_wdata   = restore_top;
      end
      default: begin
        w_tos_nxt = r_tos;
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  // Pointer and occupancy registers; reset outranks every other request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tos <= '0;
      r_cnt <= '0;
    end else begin
      r_tos <= w_tos_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  cs_ram #(
    .DEPTH (DEPTH),
    .WIDTH (IP_WIDTH),
    .AW    (PW)
  ) u_cs_ram (
    .clk     (clk),
    .i_we    (w_we && !rst),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_tos),
    .o_rdata (w_rdata)
  );

  assign top_addr = w_rdata;
  assign top_vld  = (r_cnt != '0);
  assign ckpt_ptr = r_tos;
  assign ckpt_cnt = r_cnt;

endmodule

// File: tb/tb_call_stack_pred.sv
// Bench for call_stack_pred: directed scenarios plus random traffic, with an
// expected-response queue filled by the driver and drained by a monitor.
module tb_call_stack_pred;

  localparam int DEPTH = 16;
  localparam int W     = 48;
  localparam int PW    = 4;
  localparam int CW    = 5;
  localparam int EW    = 1 + W + PW + CW;

  logic          clk;
  logic          rst;
  logic          in_en;
  logic          push_i;
  logic          pop_i;
  logic [W-1:0]  push_addr;
  logic [W-1:0]  top_addr;
  logic          top_vld;
  logic [PW-1:0] ckpt_ptr;
  logic [CW-1:0] ckpt_cnt;
  logic          restore;
  logic [PW-1:0] restore_ptr;
  logic [CW-1:0] restore_cnt;
  logic [W-1:0]  restore_top;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {top_vld, top_addr, ptr, cnt} and whether top_addr is meaningful.
  logic [EW-1:0] exp_q[$];
  logic          exp_top_q[$];

  // Reference model: plain array with modular pointer and occupancy.
  logic [W-1:0] m_mem [DEPTH];
  bit           m_wr  [DEPTH];
  int           m_tos;
  int           m_cnt;

  call_stack_pred dut (
    .clk           (clk),
    .rst           (rst),
    .in_en         (in_en),
    .pushCallStack (push_i),
    .popCallStack  (pop_i),
    .push_addr     (push_addr),
    .top_addr      (top_addr),
    .top_vld       (top_vld),
    .ckpt_ptr      (ckpt_ptr),
    .ckpt_cnt      (ckpt_cnt),
    .restore       (restore),
    .restore_ptr   (restore_ptr),
    .restore_cnt   (restore_cnt),
    .restore_top   (restore_top)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic drive(input logic r, input logic en, input logic pu, input logic po,
                       input logic [W-1:0] pa, input logic rs, input logic [PW-1:0] rp,
                       input logic [CW-1:0] rc, input logic [W-1:0] rt);
    @(negedge clk);
    rst = r; in_en = en; push_i = pu; pop_i = po; push_addr = pa;
    restore = rs; restore_ptr = rp; restore_cnt = rc; restore_top = rt;
    if (r) begin
      m_tos = 0;
      m_cnt = 0;
    end else if (rs) begin
      m_tos = int'(rp);
      m_cnt = int'(rc);
      m_mem[m_tos] = rt;
      m_wr[m_tos]  = 1'b1;
    end else if (en) begin
      if (pu && po) begin
        m_mem[m_tos] = pa;
        m_wr[m_tos]  = 1'b1;
        if (m_cnt == 0) m_cnt = 1;
      end else if (pu) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos] = pa;
        m_wr[m_tos]  = 1'b1;
        m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
      end else if (po && m_cnt > 0) begin
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt = m_cnt - 1;
      end
    end
    exp_q.push_back({(m_cnt != 0), m_mem[m_tos], PW'(m_tos), CW'(m_cnt)});
    exp_top_q.push_back((m_cnt != 0) && m_wr[m_tos]);
  endtask

  task automatic do_rst();      drive(1, 0, 0, 0, '0, 0, '0, '0, '0); endtask
  task automatic do_push(input logic [W-1:0] a); drive(0, 1, 1, 0, a, 0, '0, '0, '0); endtask
  task automatic do_pop();      drive(0, 1, 0, 1, '0, 0, '0, '0, '0); endtask
  task automatic do_swap(input logic [W-1:0] a); drive(0, 1, 1, 1, a, 0, '0, '0, '0); endtask
  task automatic do_idle();     drive(0, 0, 0, 0, '0, 0, '0, '0, '0); endtask

  // Monitor: every cycle after the active edge, compare against the oldest expectation.
  always @(posedge clk) begin
    logic [EW-1:0] e;
    logic          chk_top;
    #1;
    if (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      chk_top = exp_top_q.pop_front();
      check("top_vld",  W'(top_vld),  W'(e[EW-1]));
      check("ckpt_ptr", W'(ckpt_ptr), W'(e[CW+PW-1:CW]));
      check("ckpt_cnt", W'(ckpt_cnt), W'(e[CW-1:0]));
      if (chk_top) check("top_addr", top_addr, e[EW-2:CW+PW]);
    end
  end

  // Stimulus.
  initial begin
    logic [W-1:0]  pa;
    logic [PW-1:0] ck_ptr;
    logic [CW-1:0] ck_cnt;
    logic [W-1:0]  ck_top;
    logic          r, en, pu, po, rs;
    int            drain;

    rst = 1'b1; in_en = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_addr = '0;
    restore = 1'b0; restore_ptr = '0; restore_cnt = '0; restore_top = '0;
    m_tos = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_wr[i]  = 1'b0;
    end

    // Reset, two pushes, one pop.
    do_rst();
    do_push(48'h1000);
    do_push(48'h2000);
    do_pop();

    // Overflow by one, drain completely, then underflow.
    do_rst();
    for (int i = 1; i <= 17; i++) do_push(W'(16 * i));
    for (int i = 0; i < 17; i++) do_pop();

    // Pop on an empty stack straight after reset.
    do_rst();
    do_pop();
    do_pop();

    // Push and pop together at occupancy 3, then at occupancy 0.
    do_push(48'h100);
    do_push(48'h200);
    do_push(48'h300);
    do_swap(48'hABC0);
    do_idle();
    do_rst();
    do_swap(48'h5550);

    // Checkpoint at ptr=2, cnt=3, top=0x3000; speculate; restore with push high.
    do_rst();
    do_swap(48'h1000);
    do_push(48'h2000);
    do_push(48'h3000);
    do_pop();
    do_pop();
    do_push(48'h9990);
    drive(0, 1, 1, 0, 48'h7770, 1, 4'd2, 5'd3, 48'h3000);
    do_pop();

    // Reset in the same cycle as restore and push.
    do_push(48'h4440);
    drive(1, 1, 1, 0, 48'h6660, 1, 4'd5, 5'd7, 48'h8880);
    do_idle();

    // Restore while in_en is low still takes effect.
    drive(0, 0, 0, 0, '0, 1, 4'd9, 5'd16, 48'hBEE0);
    do_pop();

    // Random traffic with occasional checkpoints, restores and resets.
    ck_ptr = '0; ck_cnt = '0; ck_top = 48'h1230;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        ck_ptr = PW'(m_tos);
        ck_cnt = CW'(m_cnt);
        ck_top = m_wr[m_tos] ? m_mem[m_tos] : {16'($urandom), $urandom() & 32'hFFFF_FFFE};
      end
      pa = {16'($urandom), $urandom()};
      pa[0] = 1'b0;
      r  = ($urandom_range(0, 99) == 0);
      rs = ($urandom_range(0, 24) == 0);
      en = ($urandom_range(0, 9) != 0);
      pu = ($urandom_range(0, 9) < 5);
      po = ($urandom_range(0, 9) < 4);
      drive(r, en, pu, po, pa, rs, ck_ptr, ck_cnt, ck_top);
    end
    do_idle();

    // Let the monitor drain, bounded.
    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/call_stack_pred.md
CALL_STACK_PRED -- requirements
Module: call_stack_pred

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of return-address entries (power of two).
REQ-002 SHALL have parameter IP_WIDTH, default 48, return-address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_en  input  1  qualifies push/pop this cycle; low = no stack change.
REQ-006 SHALL have port pushCallStack  input  1  call decoded, from jump decoder.
REQ-007 SHALL have port popCallStack  input  1  return decoded, from jump decoder.
REQ-008 SHALL have port push_addr  input  IP_WIDTH  return address of the call; bit 0 always zero.
REQ-009 SHALL have port top_addr  output  IP_WIDTH  predicted return target (current top entry).
REQ-010 SHALL have port top_vld  output  1  stack non-empty.
REQ-011 SHALL have port ckpt_ptr  output  log2(DEPTH)  current top-of-stack index, for attaching to each branch.
REQ-012 SHALL have port ckpt_cnt  output  log2(DEPTH)+1  current occupancy, for attaching to each branch.
REQ-013 SHALL have port restore  input  1  mispredict flush; restores state from checkpoint.
REQ-014 SHALL have port restore_ptr  input  log2(DEPTH)  checkpointed index.
REQ-015 SHALL have port restore_cnt  input  log2(DEPTH)+1  checkpointed occupancy.
REQ-016 SHALL have port restore_top  input  IP_WIDTH  checkpointed top entry value.

Function
REQ-017 SHALL hold a circular array of DEPTH entries, a pointer tos, and a count cnt (0..DEPTH).
REQ-018 SHALL drive top_addr = entry[tos] and top_vld = (cnt != 0) combinationally, with zero-cycle read latency.
REQ-019 SHALL drive ckpt_ptr = tos and ckpt_cnt = cnt, both registered state.
REQ-020 SHALL, on push only (in_en=1): tos <= tos+1 mod DEPTH; entry[tos+1] <= push_addr; cnt <= min(cnt+1, DEPTH).
REQ-021 SHALL, on push at cnt=DEPTH, overwrite the oldest entry (wrap-around); cnt stays DEPTH.
REQ-022 SHALL, on pop only with cnt>0: tos <= tos-1 mod DEPTH; cnt <= cnt-1; entry contents unchanged.
REQ-023 SHALL, on pop at cnt=0 (underflow), change nothing; top_vld stays 0.
REQ-024 SHALL, on push and pop in the same cycle: entry[tos] <= push_addr; tos and cnt unchanged; if cnt=0, cnt <= 1.
REQ-025 SHALL, on restore=1: tos <= restore_ptr; cnt <= restore_cnt; entry[restore_ptr] <= restore_top; push/pop ignored that cycle.
REQ-026 SHALL ignore push/pop when in_en=0; restore SHALL act regardless of in_en.
REQ-027 SHALL make all state updates visible on top_addr and ckpt_* one cycle after the triggering edge.

Reset
REQ-028 SHALL, on rst: tos=0, cnt=0, top_vld=0, ckpt_ptr=0, ckpt_cnt=0; entry contents SHALL be left uncleared; top_addr is don't-care while top_vld=0.
REQ-029 SHALL give rst priority over restore, push and pop in the same cycle.

Structure
REQ-030 SHALL take the IP_WIDTH and DEPTH defaults from the shared struct package constants already used by the jump decoder.
REQ-031 SHALL implement the entry array as one sub-module, cs_ram (1 write port, 1 async read port), with all pointer logic kept in call_stack_pred.

Verification
REQ-032 SHALL cover: reset, push 0x1000, 0x2000 -> top_addr=0x2000, cnt=2; pop -> top_addr=0x1000, cnt=1.
REQ-033 SHALL cover: 17 pushes of 0x10*i (i=1..17) at DEPTH=16 -> cnt=16, top=0x110; 16 pops -> last valid top=0x20; 17th pop -> top_vld=0, no change.
REQ-034 SHALL cover: pop at cnt=0 -> tos=0, cnt=0 unchanged.
REQ-035 SHALL cover: push+pop same cycle at cnt=3, push_addr=0xABC0 -> cnt=3, tos unchanged, top=0xABC0.
REQ-036 SHALL cover: checkpoint (ptr=2, cnt=3, top=0x3000), then 2 pops and 1 push of 0x9990, then restore -> top=0x3000, cnt=3, ptr=2; push asserted in the restore cycle is ignored.
REQ-037 SHALL cover: rst asserted mid-sequence with restore and push high -> next cycle cnt=0, tos=0, top_vld=0.
